stream_demultiplexer: RTL and testbench

- Receive end of the 16-bit multiplexed data stream: takes one word per cycle, tagged with the 2-bit mode channel select, and routes it back onto one of three independent output channels.
- Each channel has a small FIFO and a valid/ready handshake, so a stalled consumer back-pressures only words addressed to it.
- Mode 0 carries no channel. Words with mode 0 are accepted, discarded and counted.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/demux_chan_fifo.sv | 51 +++++
 rtl/stream_demultiplexer.sv | 89 ++++++++
 tb/tb_stream_demultiplexer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Definitions shared by the transmit-side multiplexer and the receive-side
// demultiplexer of the 16-bit multiplexed stream.
package stream_mux_pkg;

    localparam int STREAM_DATA_W = 16;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_CH1  = 2'd1,
        MODE_CH2  = 2'd2,
        MODE_CH3  = 2'd3
    } mode_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO: one-bit-wider pointers distinguish full from empty;
// the head word is shown directly (registered storage, no input bypass).
module demux_chan_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign not_empty = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push   = push & ~full;
    assign do_pop    = pop & not_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; emptying the pointers discards
    // its contents and the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = not_empty ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/stream_demultiplexer.sv
// Receive end of the multiplexed stream: routes each tagged word into one of
// three channel FIFOs, or drops and counts it when the tag is MODE_NONE.
module stream_demultiplexer
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] multiplexed_data,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_1_data,
    output logic [DATA_W-1:0] out_2_data,
    output logic [DATA_W-1:0] out_3_data,
    output logic              out_1_valid,
    output logic              out_2_valid,
    output logic              out_3_valid,
    input  logic              out_1_ready,
    input  logic              out_2_ready,
    input  logic              out_3_ready,
    output logic [CNT_W-1:0]  drop_count
);

    logic [3:0]        full_vec;
    logic [3:1]        not_empty_vec;
    logic [3:1]        ready_vec;
    logic [3:1]        push_vec;
    logic [DATA_W-1:0] head [1:3];
    logic              accept;
    logic              drop;

    // Slot 0 stands for MODE_NONE, which is never full, so in_ready depends
    // only on mode and registered FIFO state.
    assign full_vec[0] = 1'b0;
    assign in_ready    = ~full_vec[mode];
    assign accept      = in_valid & in_ready;
    assign ready_vec   = {out_3_ready, out_2_ready, out_1_ready};

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_vec = '0;
        drop     = 1'b0;
        if (accept) begin
            case (mode_e'(mode))
                MODE_NONE: drop        = 1'b1;
                MODE_CH1:  push_vec[1] = 1'b1;
                MODE_CH2:  push_vec[2] = 1'b1;
                MODE_CH3:  push_vec[3] = 1'b1;
            endcase
        end
    end

    for (genvar n = 1; n <= 3; n++) begin : g_chan
        demux_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[n]),
            .push_data (multiplexed_data),
            .full      (full_vec[n]),
            .pop       (not_empty_vec[n] & ready_vec[n]),
            .head_data (head[n]),
            .not_empty (not_empty_vec[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign out_1_data  = head[1];
    assign out_2_data  = head[2];
    assign out_3_data  = head[3];
    assign out_1_valid = not_empty_vec[1];
    assign out_2_valid = not_empty_vec[2];
    assign out_3_valid = not_empty_vec[3];

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed bench for stream_demultiplexer: routing, latency, back-pressure,
// wrap-around, drop counting with saturation, and asynchronous reset.
module tb_stream_demultiplexer;

    logic        clk;
    logic        rst_n;
    logic [15:0] multiplexed_data;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_1_data, out_2_data, out_3_data;
    logic        out_1_valid, out_2_valid, out_3_valid;
    logic        out_1_ready, out_2_ready, out_3_ready;
    logic [15:0] drop_count;

    logic        sat_in_ready;
    logic [15:0] sat_1_data, sat_2_data, sat_3_data;
    logic        sat_1_valid, sat_2_valid, sat_3_valid;
    logic [3:0]  sat_drop_count;

    int n_checks = 0;
    int n_errors = 0;

    stream_demultiplexer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .multiplexed_data (multiplexed_data),
        .mode             (mode),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_1_data       (out_1_data),
        .out_2_data       (out_2_data),
        .out_3_data       (out_3_data),
        .out_1_valid      (out_1_valid),
        .out_2_valid      (out_2_valid),
        .out_3_valid      (out_3_valid),
        .out_1_ready      (out_1_ready),
        .out_2_ready      (out_2_ready),
        .out_3_ready      (out_3_ready),
        .drop_count       (drop_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    stream_demultiplexer #(.CNT_W(4)) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .multiplexed_data (multiplexed_data),
        .mode             (mode),
        .in_valid         (in_valid),
        .in_ready         (sat_in_ready),
        .out_1_data       (sat_1_data),
        .out_2_data       (sat_2_data),
        .out_3_data       (sat_3_data),
        .out_1_valid      (sat_1_valid),
        .out_2_valid      (sat_2_valid),
        .out_3_valid      (sat_3_valid),
        .out_1_ready      (out_1_ready),
        .out_2_ready      (out_2_ready),
        .out_3_ready      (out_3_ready),
        .drop_count       (sat_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d);
        in_valid         = v;
        mode             = m;
        multiplexed_data = d;
    endtask

    task automatic check_valids(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, out_3_valid, out_2_valid, out_1_valid}, {29'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0000);
        out_1_ready = 1'b0;
        out_2_ready = 1'b0;
        out_3_ready = 1'b0;

        // Reset / idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_valids("rst_valids", 3'b000);
        check("rst_d1", out_1_data, 16'h0);
        check("rst_d2", out_2_data, 16'h0);
        check("rst_d3", out_3_data, 16'h0);
        check("rst_drop", drop_count, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // Routing and one-cycle latency
        out_1_ready = 1'b1; out_2_ready = 1'b1; out_3_ready = 1'b1;
        drive(1'b1, 2'd1, 16'h1111);
        @(negedge clk);
        check_valids("route1_valids", 3'b001);
        check("route1_data", out_1_data, 16'h1111);
        drive(1'b1, 2'd2, 16'h2222);
        @(negedge clk);
        check_valids("route2_valids", 3'b010);
        check("route2_data", out_2_data, 16'h2222);
        drive(1'b1, 2'd3, 16'h3333);
        @(negedge clk);
        check_valids("route3_valids", 3'b100);
        check("route3_data", out_3_data, 16'h3333);
        drive(1'b0, 2'd0, 16'h0);
        @(negedge clk);
        check_valids("route_idle", 3'b000);

        // Back-pressure on channel 2, channel 1 unaffected
        out_2_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 16'hA000 + 16'(i));
            #1 check($sformatf("bp_ready_%0d", i), in_ready, 1'b1);
            @(negedge clk);
        end
        drive(1'b1, 2'd2, 16'hA004);
        #1 check("bp_full_ready", in_ready, 1'b0);
        drive(1'b1, 2'd1, 16'hB001);
        #1 check("bp_other_ready", in_ready, 1'b1);
        @(negedge clk);
        check("bp_other_data", out_1_data, 16'hB001);
        check("bp_other_valid", out_1_valid, 1'b1);
        drive(1'b1, 2'd2, 16'hA004);
        #1 check("bp_still_full", in_ready, 1'b0);
        check("bp_head_stable", out_2_data, 16'hA000);
        out_2_ready = 1'b1;
        #1 check("bp_no_rdy_path", in_ready, 1'b0);
        @(negedge clk);
        check("bp_drain0", out_2_data, 16'hA001);
        check("bp_after_full", in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 16'h0);
        check("bp_drain1", out_2_data, 16'hA002);
        @(negedge clk);
        check("bp_drain2", out_2_data, 16'hA003);
        @(negedge clk);
        check("bp_drain3", out_2_data, 16'hA004);
        @(negedge clk);
        check_valids("bp_empty", 3'b000);

        // Channel 3 held at two entries while pushing and popping each cycle
        out_3_ready = 1'b0;
        drive(1'b1, 2'd3, 16'h0300);
        @(negedge clk);
        drive(1'b1, 2'd3, 16'h0301);
        @(negedge clk);
        out_3_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 2'd3, 16'h0302 + 16'(j));
            #1 check($sformatf("wrap_head_%0d", j), out_3_data, 16'h0300 + 16'(j));
            check($sformatf("wrap_ready_%0d", j), in_ready, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 2'd0, 16'h0);
        out_3_ready = 1'b0;
        check("wrap_tail0", out_3_data, 16'h030A);
        out_3_ready = 1'b1;
        @(negedge clk);
        check("wrap_tail1", out_3_data, 16'h030B);
        @(negedge clk);
        check_valids("wrap_empty", 3'b000);

        // Fill every channel, then drop mode-0 words
        out_1_ready = 1'b0; out_2_ready = 1'b0; out_3_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 2'(c), 16'hC000 + 16'(c * 16 + i));
                @(negedge clk);
            end
        end
        drive(1'b0, 2'd1, 16'h0);
        #1 check("full1_ready", in_ready, 1'b0);
        drive(1'b0, 2'd3, 16'h0);
        #1 check("full3_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 16'hDD00 + 16'(i));
            #1 check($sformatf("drop_ready_%0d", i), in_ready, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 2'd0, 16'h0);
        check("drop_count3", drop_count, 16'd3);
        check("sat_count3", sat_drop_count, 4'd3);
        check_valids("drop_valids", 3'b111);
        check("drop_head1", out_1_data, 16'hC010);
        check("drop_head2", out_2_data, 16'hC020);
        check("drop_head3", out_3_data, 16'hC030);

        // Asynchronous reset with channel 1 holding three words
        out_1_ready = 1'b1;
        @(negedge clk);
        out_1_ready = 1'b0;
        check("pre_rst_head1", out_1_data, 16'hC011);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_valid1", out_1_valid, 1'b0);
        check("async_drop", drop_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_valids("post_rst_valids", 3'b000);
        check("post_rst_d1", out_1_data, 16'h0);
        check("post_rst_drop", drop_count, 16'd0);
        check("post_rst_in_ready", in_ready, 1'b1);

        // Saturation of the 4-bit drop counter
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'd0, 16'h0);
            @(negedge clk);
        end
        check("sat_at_15", sat_drop_count, 4'd15);
        repeat (2) @(negedge clk);
        drive(1'b0, 2'd0, 16'h0);
        check("sat_hold_15", sat_drop_count, 4'd15);
        check("wide_count_17", drop_count, 16'd17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
